// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI mode-0 master; one 32-bit {cmd, data} register frame per start.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        ssel,
  input  logic        miso
);

  localparam int c_DIV_W = $clog2(CLK_DIV) + 1;
  localparam int c_GAP_W = $clog2(IDLE_CYCLES) + 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(IDLE_CYCLES - 1);
  localparam logic [5:0] c_LAST_BIT = 6'd32;
  localparam logic [5:0] c_FIRST_RX = 6'd16;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SETUP = 3'd1;
  localparam logic [2:0] c_ST_SHIFT = 3'd2;
  localparam logic [2:0] c_ST_HOLD  = 3'd3;
  localparam logic [2:0] c_ST_GAP   = 3'd4;

  logic [2:0]         r_state,     w_state_nxt;
  logic [c_DIV_W-1:0] r_div_cnt,   w_div_cnt_nxt;
  logic [c_GAP_W-1:0] r_gap_cnt,   w_gap_cnt_nxt;
  logic [31:0]        r_tx,        w_tx_nxt;
  logic [15:0]        r_rx,        w_rx_nxt;
  logic [5:0]         r_bit_cnt,   w_bit_cnt_nxt;
  logic               r_wr,        w_wr_nxt;
  logic [15:0]        r_rd_data,   w_rd_data_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_sclk,      w_sclk_nxt;
  logic               r_ssel,      w_ssel_nxt;

  logic w_div_tick;
  logic w_gap_tick;

  assign w_div_tick = (r_div_cnt == c_DIV_LAST);
  assign w_gap_tick = (r_gap_cnt == c_GAP_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= c_ST_IDLE;
      r_div_cnt <= '0;
      r_gap_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_wr      <= 1'b0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_ssel    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_wr      <= w_wr_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_sclk    <= w_sclk_nxt;
      r_ssel    <= w_ssel_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start) w_state_nxt = c_ST_SETUP;
      c_ST_SETUP: if (w_div_tick) w_state_nxt = c_ST_SHIFT;
      // The last low half-period runs to completion before HOLD, so sclk
      // never shows a shortened low phase after bit 32.
      c_ST_SHIFT: if (w_div_tick && !r_sclk && (r_bit_cnt == c_LAST_BIT))
                    w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:  if (w_div_tick) w_state_nxt = c_ST_GAP;
      c_ST_GAP:   if (w_gap_tick) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_div_cnt_nxt = '0;
    w_gap_cnt_nxt = '0;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_bit_cnt_nxt = r_bit_cnt;
    w_wr_nxt      = r_wr;
    w_rd_data_nxt = r_rd_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_sclk_nxt    = r_sclk;
    w_ssel_nxt    = r_ssel;

    if ((r_state == c_ST_SETUP) || (r_state == c_ST_SHIFT) || (r_state == c_ST_HOLD))
      w_div_cnt_nxt = w_div_tick ? '0 : r_div_cnt + 1'b1;
    if (r_state == c_ST_GAP)
      w_gap_cnt_nxt = w_gap_tick ? '0 : r_gap_cnt + 1'b1;

    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_tx_nxt      = {wr, 11'b0, addr, (wr ? wr_data : 16'h0000)};
          w_bit_cnt_nxt = '0;
          w_wr_nxt      = wr;
          w_ssel_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      c_ST_SETUP: begin
        if (w_div_tick) begin
          w_sclk_nxt    = 1'b1;
          w_bit_cnt_nxt = 6'd1;
        end
      end
      c_ST_SHIFT: begin
        if (w_div_tick) begin
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt != c_LAST_BIT)
              w_tx_nxt = {r_tx[30:0], 1'b0};
          end else if (r_bit_cnt != c_LAST_BIT) begin
            w_sclk_nxt    = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
            // Rising edges 17..32 carry the read payload
            if (r_bit_cnt >= c_FIRST_RX)
              w_rx_nxt = {r_rx[14:0], miso};
          end
        end
      end
      c_ST_HOLD: begin
        if (w_div_tick) begin
          w_ssel_nxt = 1'b1;
          w_done_nxt = 1'b1;
          if (!r_wr)
            w_rd_data_nxt = r_rx;
        end
      end
      c_ST_GAP: begin
        if (w_gap_tick)
          w_busy_nxt = 1'b0;
      end
      default: begin
        w_ssel_nxt = 1'b1;
        w_sclk_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign rd_data = r_rd_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = r_sclk;
  assign ssel    = r_ssel;
  assign mosi    = r_tx[31];

endmodule
`default_nettype wire
